// File: rtl/remote_comm_pkg.sv
// Shared constants for the remote command link: opcodes, acknowledge byte,
// and a helper to build a command word.
package remote_comm_pkg;

    localparam logic [2:0] OP_CAL   = 3'b000;
    localparam logic [2:0] OP_HDNG  = 3'b001;
    localparam logic [2:0] OP_MOVE  = 3'b010;
    localparam logic [2:0] OP_SOLVE = 3'b011;

    localparam logic [7:0] ACK = 8'hA5;

    localparam int STATE_W = 2;

    // Bit 12 is unused by the command format and is sent as zero.
    function automatic logic [15:0] make_cmd(input logic [2:0] op, input logic [11:0] operand);
        return {op, 1'b0, operand};
    endfunction

endpackage

// File: rtl/remote_comm_if.sv
// Command/response bus between a requester and remote_comm.
interface remote_comm_if;
    import remote_comm_pkg::*;

    // snd_cmd is a request that is accepted only on an edge where busy is low
    // (busy low acts as ready); cmd must be stable on that edge. cmd_snt and
    // timeout are one-cycle pulses; resp is valid while resp_rdy is high.
    logic [15:0]        cmd;
    logic               snd_cmd;
    logic               cmd_snt;
    logic [7:0]         resp;
    logic               resp_rdy;
    logic               timeout;
    logic               busy;
    logic [STATE_W-1:0] state;

    modport master (
        output cmd, snd_cmd,
        input  cmd_snt, resp, resp_rdy, timeout, busy, state
    );

    modport slave (
        input  cmd, snd_cmd,
        output cmd_snt, resp, resp_rdy, timeout, busy, state
    );

endinterface

// File: rtl/remote_comm_uart.sv
// 8N1 UART. tx_done is a level set at the end of the stop bit and cleared
// by the next trmt; rx_rdy is set at mid stop bit and cleared by clr_rx_rdy.
module remote_comm_uart #(
    parameter int BAUD_CYC = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_i,
    output logic       tx_o,
    input  logic       trmt_i,
    input  logic [7:0] tx_data_i,
    output logic       tx_done_o,
    output logic       rx_rdy_o,
    output logic [7:0] rx_data_o,
    input  logic       clr_rx_rdy_i
);

    localparam int            CW       = $clog2(BAUD_CYC);
    localparam logic [CW-1:0] BIT_END  = CW'(BAUD_CYC - 1);
    localparam logic [CW-1:0] HALF_BIT = CW'(BAUD_CYC / 2 - 1);

    logic          tx_busy_q;
    logic [9:0]    tx_shift_q;
    logic [CW-1:0] tx_baud_q;
    logic [3:0]    tx_bit_q;
    logic          tx_done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_busy_q  <= 1'b0;
            tx_shift_q <= '1;
            tx_baud_q  <= '0;
            tx_bit_q   <= '0;
            tx_done_q  <= 1'b0;
        end else if (trmt_i) begin
            tx_busy_q  <= 1'b1;
            tx_shift_q <= {1'b1, tx_data_i, 1'b0};
            tx_baud_q  <= '0;
            tx_bit_q   <= '0;
            tx_done_q  <= 1'b0;
        end else if (tx_busy_q) begin
            if (tx_baud_q == BIT_END) begin
                tx_baud_q  <= '0;
                tx_shift_q <= {1'b1, tx_shift_q[9:1]};
                if (tx_bit_q == 4'd9) begin
                    tx_busy_q <= 1'b0;
                    tx_done_q <= 1'b1;
                end else begin
                    tx_bit_q <= tx_bit_q + 4'd1;
                end
            end else begin
                tx_baud_q <= tx_baud_q + CW'(1);
            end
        end
    end

    // Combinational from flops so reset forces the line idle immediately.
    assign tx_o      = tx_busy_q ? tx_shift_q[0] : 1'b1;
    assign tx_done_o = tx_done_q;

    logic          rx_meta_q;
    logic          rx_sync_q;
    logic          rx_busy_q;
    logic [CW-1:0] rx_cnt_q;
    logic [3:0]    rx_bit_q;
    logic [7:0]    rx_shift_q;
    logic [7:0]    rx_data_q;
    logic          rx_rdy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_busy_q  <= 1'b0;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_rdy_q   <= 1'b0;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
            if (clr_rx_rdy_i) begin
                rx_rdy_q <= 1'b0;
            end
            if (!rx_busy_q) begin
                if (!rx_sync_q) begin
                    rx_busy_q <= 1'b1;
                    rx_cnt_q  <= HALF_BIT;
                    rx_bit_q  <= '0;
                end
            end else if (rx_cnt_q != '0) begin
                rx_cnt_q <= rx_cnt_q - CW'(1);
            end else begin
                rx_cnt_q <= BIT_END;
                if (rx_bit_q == 4'd0) begin
                    // A start bit that is high again at mid-bit was a glitch.
                    if (rx_sync_q) begin
                        rx_busy_q <= 1'b0;
                    end else begin
                        rx_bit_q <= 4'd1;
                    end
                end else if (rx_bit_q == 4'd9) begin
                    rx_busy_q <= 1'b0;
                    rx_data_q <= rx_shift_q;
                    rx_rdy_q  <= 1'b1;
                end else begin
                    rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
                    rx_bit_q   <= rx_bit_q + 4'd1;
                end
            end
        end
    end

    assign rx_rdy_o  = rx_rdy_q;
    assign rx_data_o = rx_data_q;

endmodule

// File: rtl/remote_comm.sv
// Sends a 16-bit command as two UART bytes (high first), then waits a
// bounded time for a single response byte.
module remote_comm
    import remote_comm_pkg::*;
#(
    parameter int BAUD_CYC    = 434,
    parameter int TIMEOUT_CYC = 25_000_000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          RX,
    output logic          TX,
    remote_comm_if.slave  bus
);

    typedef enum logic [STATE_W-1:0] {IDLE, TX_HI, TX_LO, WAIT_RESP} state_t;

    localparam int            TW   = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [TW-1:0] TERM = TW'(TIMEOUT_CYC - 1);

    state_t        state_q, state_d;
    logic [7:0]    lo_q, lo_d;
    logic [7:0]    resp_q, resp_d;
    logic          resp_rdy_q, resp_rdy_d;
    logic [TW-1:0] cnt_q, cnt_d;

    logic       trmt;
    logic [7:0] tx_data;
    logic       tx_done;
    logic       rx_rdy;
    logic [7:0] rx_data;
    logic       clr_rx_rdy;
    logic       cmd_snt;
    logic       timeout;

    remote_comm_uart #(.BAUD_CYC(BAUD_CYC)) u_uart (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_i         (RX),
        .tx_o         (TX),
        .trmt_i       (trmt),
        .tx_data_i    (tx_data),
        .tx_done_o    (tx_done),
        .rx_rdy_o     (rx_rdy),
        .rx_data_o    (rx_data),
        .clr_rx_rdy_i (clr_rx_rdy)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            lo_q       <= '0;
            resp_q     <= 8'h00;
            resp_rdy_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            lo_q       <= lo_d;
            resp_q     <= resp_d;
            resp_rdy_q <= resp_rdy_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        lo_d       = lo_q;
        resp_d     = resp_q;
        resp_rdy_d = resp_rdy_q;
        cnt_d      = cnt_q;
        trmt       = 1'b0;
        tx_data    = lo_q;
        clr_rx_rdy = 1'b0;
        cmd_snt    = 1'b0;
        timeout    = 1'b0;

        // Outside WAIT_RESP any received byte is unsolicited and dropped.
        if (rx_rdy && state_q != WAIT_RESP) begin
            clr_rx_rdy = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (bus.snd_cmd) begin
                    lo_d       = bus.cmd[7:0];
                    trmt       = 1'b1;
                    tx_data    = bus.cmd[15:8];
                    resp_rdy_d = 1'b0;
                    state_d    = TX_HI;
                end
            end
            TX_HI: begin
                if (tx_done) begin
                    trmt    = 1'b1;
                    tx_data = lo_q;
                    state_d = TX_LO;
                end
            end
            TX_LO: begin
                if (tx_done) begin
                    cmd_snt = 1'b1;
                    cnt_d   = '0;
                    state_d = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                // A response arriving on the terminal cycle still wins.
                if (rx_rdy) begin
                    resp_d     = rx_data;
                    resp_rdy_d = 1'b1;
                    clr_rx_rdy = 1'b1;
                    state_d    = IDLE;
                end else if (cnt_q == TERM) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.cmd_snt  = cmd_snt;
    assign bus.timeout  = timeout;
    assign bus.resp     = resp_q;
    assign bus.resp_rdy = resp_rdy_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.state    = state_q;

endmodule
